gpio_config_register: RTL
=========================

# gpio_config_register

Per-pad configuration register sitting directly downstream of `gpio_defaults_block`, one instance per GPIO pad. Takes the 10-bit `gpio_defaults` word as its power-on and reload value, and accepts new configuration words from the management serial chain. Uses an exact-length check before committing a word, then decodes the active word into individual pad control outputs. Instances are daisy-chained through `serial_data_in` / `serial_data_out`.

## Interface
Parameters:
- `CFG_W`, 10: configuration word width; must match `gpio_defaults` width.
- `CNT_W`, 4: shift-counter width; must satisfy 2^CNT_W > CFG_W+1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `gpio_defaults`  in  10  default word from `gpio_defaults_block`; static.
- `serial_shift`  in  1  shift strobe, one bit per high cycle.
- `serial_data_in`  in  1  chain input bit, sampled when `serial_shift`=1.
- `serial_load`  in  1  commit strobe: shift register to active config.
- `defaults_reload`  in  1  reapply `gpio_defaults` to active config.
- `serial_data_out`  out  1  chain output to the next pad (shift register MSB).
- `cfg_word`  out  10  active configuration word.
- `cfg_err`  out  1  sticky flag: a load was rejected.
- `pad_mgmt_ena`, `pad_oe_ovr`, `pad_ie`, `pad_pu`, `pad_pd`, `pad_schmitt`, `pad_slew`, `pad_hold`  out  1 each  decoded from bits 0..6 and 9.
- `pad_drive`  out  2  decoded from bits 8:7.

## Operation
- Bit map (shared package): 0 MGMT_EN, 1 OE_OVR, 2 IE, 3 PU, 4 PD, 5 SCHMITT, 6 SLEW, 8:7 DRIVE, 9 HOLD.
- State: `shift_reg[9:0]`, `cfg_reg[9:0]`, `shift_cnt[CNT_W-1:0]`, `err_reg`.
- Shift: when `serial_shift`=1, `shift_reg` <= {shift_reg[8:0], serial_data_in}, so data is MSB first. `shift_cnt` increments and saturates at 11, which means "more than 10".
- `serial_data_out` = `shift_reg[9]`, a registered value. The next pad therefore sees this pad's bit shifted out 10 shifts later.
- Load: when `serial_load`=1:
  - If `shift_cnt`==10, `cfg_reg` <= `shift_reg`.
  - Otherwise `cfg_reg` is unchanged and `err_reg` <= 1.
  - In both cases `shift_cnt` <= 0. `shift_reg` is retained.
- Priority in a single cycle, highest first: `reset` > `defaults_reload` > `serial_load` > `serial_shift`.
  - `defaults_reload`: `cfg_reg` <= `gpio_defaults`, `shift_cnt` <= 0, `err_reg` <= 0. Any concurrent load or shift is dropped.
  - `serial_load` together with `serial_shift`: the load uses the pre-shift `shift_reg` and count; the shift is dropped.
- `err_reg` clears only on `reset` or `defaults_reload`.
- PU/PD conflict: if bits 3 and 4 are both 1, `pad_pd` is forced to 0 and `pad_pu`=1. `cfg_word` still reports both bits set.
- Reset (synchronous) values:
  - `cfg_reg` = `gpio_defaults` sampled on the reset cycle.
  - `shift_reg`=0, `shift_cnt`=0, `err_reg`=0, `serial_data_out`=0.
  - Pad outputs follow the defaults, e.g. 10'h007 gives mgmt_ena=1, oe_ovr=1, ie=1, all others 0.
- Reset mid-shift: the partial word is discarded and the counter is cleared.

## Timing
- All outputs are registered or decoded purely from registers. No input-to-output combinational path.
- Shift to `serial_data_out` update: 1 cycle.
- `serial_load` to `cfg_word` / pad outputs valid: 1 cycle after the strobe edge.
- `defaults_reload` to outputs: 1 cycle.
- Back-to-back shifts are allowed on every cycle. A load may immediately follow the 10th shift, on the next cycle.
- Chain of N pads: a full load needs 10·N shift cycles followed by one common `serial_load` cycle.

## Structure
- Package `gpio_cfg_pkg`:
  - `CFG_W`.
  - Bit-index constants `CFG_MGMT_EN` … `CFG_HOLD`, and `CFG_DRIVE_LSB` / `CFG_DRIVE_MSB`.
  - `CFG_DEFAULT_INIT` = 10'h007.
  - Shared with the management-side serial loader.
- One sub-module, `gpio_config_decode`: combinational word-to-pad decode, including PU/PD arbitration. Reused by the housekeeping readback.
- Top module contains only the shift, count, commit and error logic.

## Test plan
- Reset with `gpio_defaults`=10'h007 → `cfg_word`=10'h007; mgmt_ena, oe_ovr, ie =1; all other pad outputs 0; `serial_data_out`=0; `cfg_err`=0.
- Shift 10'h2A5 MSB first over 10 cycles, then `serial_load` → next cycle `cfg_word`=10'h2A5, `pad_drive`=2'b01, `pad_hold`=1, `cfg_err`=0.
- Shift 9 bits then load → `cfg_word` unchanged, `cfg_err`=1. Shift 12 bits then load → rejected, `cfg_err` stays 1. `defaults_reload` → `cfg_err`=0, `cfg_word`=`gpio_defaults`.
- Two chained instances, shift 20 bits {10'h3F0, 10'h00F}, load → first-shifted word lands in the far instance: far=10'h3F0, near=10'h00F.
- Same-cycle `serial_load`+`serial_shift` after 10 shifts → load commits the pre-shift word; the counter ends at 0, not 1. Same-cycle `defaults_reload`+`serial_load` → defaults win.
- Shift 10'h018 (PU and PD set) and load → `cfg_word`=10'h018, `pad_pu`=1, `pad_pd`=0. Assert `reset` after 5 shifts → the next 10-shift load succeeds with no error.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared GPIO pad configuration definitions: word layout, bit positions and the
// decoded pad control bundle. Also used by the management-side serial loader.
package gpio_cfg_pkg;

    localparam int CFG_W = 10;

    localparam int CFG_MGMT_EN   = 0;
    localparam int CFG_OE_OVR    = 1;
    localparam int CFG_IE        = 2;
    localparam int CFG_PU        = 3;
    localparam int CFG_PD        = 4;
    localparam int CFG_SCHMITT   = 5;
    localparam int CFG_SLEW      = 6;
    localparam int CFG_DRIVE_LSB = 7;
    localparam int CFG_DRIVE_MSB = 8;
    localparam int CFG_HOLD      = 9;

    localparam logic [CFG_W-1:0] CFG_DEFAULT_INIT = 10'h007;

    typedef struct packed {
        logic       hold;
        logic [1:0] drive;
        logic       slew;
        logic       schmitt;
        logic       pd;
        logic       pu;
        logic       ie;
        logic       oe_ovr;
        logic       mgmt_ena;
    } pad_ctrl_t;

endpackage

// File: rtl/gpio_config_decode.sv
// Combinational configuration-word to pad-control decode, including pull-up /
// pull-down arbitration. Also reused by the housekeeping readback path.
module gpio_config_decode
    import gpio_cfg_pkg::*;
(
    input  logic [CFG_W-1:0] cfg_word,
    output pad_ctrl_t        pad
);

    logic pu_pd_conflict;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        pad            = '0;
        pu_pd_conflict = cfg_word[CFG_PU] & cfg_word[CFG_PD];

        pad.mgmt_ena = cfg_word[CFG_MGMT_EN];
        pad.oe_ovr   = cfg_word[CFG_OE_OVR];
        pad.ie       = cfg_word[CFG_IE];
        pad.pu       = cfg_word[CFG_PU];
        // Enabling both pulls would fight on the pad; pull-up wins.
        pad.pd       = cfg_word[CFG_PD] & ~pu_pd_conflict;
        pad.schmitt  = cfg_word[CFG_SCHMITT];
        pad.slew     = cfg_word[CFG_SLEW];
        pad.drive    = cfg_word[CFG_DRIVE_MSB:CFG_DRIVE_LSB];
        pad.hold     = cfg_word[CFG_HOLD];
    end

endmodule

// File: rtl/gpio_config_register.sv
// Per-pad configuration register: serial shift chain, exact-length commit check,
// sticky load-error flag and reload from the static defaults word.
module gpio_config_register #(
    parameter int CFG_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CFG_W-1:0] gpio_defaults,
    input  logic             serial_shift,
    input  logic             serial_data_in,
    input  logic             serial_load,
    input  logic             defaults_reload,
    output logic             serial_data_out,
    output logic [CFG_W-1:0] cfg_word,
    output logic             cfg_err,
    output logic             pad_mgmt_ena,
    output logic             pad_oe_ovr,
    output logic             pad_ie,
    output logic             pad_pu,
    output logic             pad_pd,
    output logic             pad_schmitt,
    output logic             pad_slew,
    output logic             pad_hold,
    output logic [1:0]       pad_drive
);

    import gpio_cfg_pkg::*;

    // Count value that marks a complete word, and the saturation value that
    // stands for "more than a full word".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0] shift_reg;
    logic [CFG_W-1:0] cfg_reg;
    logic [CNT_W-1:0] shift_cnt;
    logic             err_reg;
    pad_ctrl_t        pad;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            shift_reg <= '0;
            cfg_reg   <= gpio_defaults;
            shift_cnt <= '0;
            err_reg   <= 1'b0;
        end else if (defaults_reload) begin
            cfg_reg   <= gpio_defaults;
            shift_cnt <= '0;
            err_reg   <= 1'b0;
        end else if (serial_load) begin
            // A concurrent shift is dropped; the commit sees the pre-shift word.
            if (shift_cnt == CNT_FULL) begin
                cfg_reg <= shift_reg;
            end else begin
                err_reg <= 1'b1;
            end
            shift_cnt <= '0;
        end else if (serial_shift) begin
            shift_reg <= {shift_reg[CFG_W-2:0], serial_data_in};
            if (shift_cnt != CNT_SAT) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
        end
    end

    gpio_config_decode u_decode (
        .cfg_word (cfg_reg),
        .pad      (pad)
    );

    assign serial_data_out = shift_reg[CFG_W-1];
    assign cfg_word        = cfg_reg;
    assign cfg_err         = err_reg;
    assign pad_mgmt_ena    = pad.mgmt_ena;
    assign pad_oe_ovr      = pad.oe_ovr;
    assign pad_ie          = pad.ie;
    assign pad_pu          = pad.pu;
    assign pad_pd          = pad.pd;
    assign pad_schmitt     = pad.schmitt;
    assign pad_slew        = pad.slew;
    assign pad_hold        = pad.hold;
    assign pad_drive       = pad.drive;

endmodule
